// File: rtl/inst_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// inst_mem_responder_pkg
// Shared types, constants and the address check used by fetch and load ports.
// Rev 1.0 - initial release
// ============================================================================
package inst_mem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [31:0] FAULT_DATA        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8000_0000;

    // 33-bit compare keeps base + 4*depth from wrapping past 2^32
    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input int          depth);
        logic [32:0] a;
        logic [32:0] lo;
        logic [32:0] hi;
        a  = {1'b0, addr};
        lo = {1'b0, base};
        hi = lo + (33'(depth) << 2);
        return (addr[1:0] == 2'b00) && (a >= lo) && (a < hi);
    endfunction

endpackage
`default_nettype wire

// File: rtl/inst_mem_array.sv
`default_nettype none
// ============================================================================
// inst_mem_array
// Word store with one byte-masked write port and one registered read port.
// Rev 1.0 - initial release
// ============================================================================
module inst_mem_array #(
    parameter  int DEPTH_WORDS = 4096,
    localparam int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_idx,
    input  logic [3:0]    wr_mask,
    input  logic [31:0]   wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_idx,
    output logic [31:0]   rd_data
);

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rd_data_q;

    // Read and write share an edge; nonblocking update gives read-before-write
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data_q <= mem[rd_idx];
        end
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_mask[i]) begin
                    mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    assign rd_data = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/inst_mem_responder.sv
`default_nettype none
// ============================================================================
// inst_mem_responder
// Instruction-fetch responder: one fetch in flight, fixed latency, preload port.
// Rev 1.0 - initial release
// ============================================================================
module inst_mem_responder
    import inst_mem_responder_pkg::*;
#(
    parameter int          DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int          LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    input  logic        ld_en,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data,
    input  logic [3:0]  ld_wmask
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_e      state_q,     state_d;
    logic [3:0]  cnt_q,       cnt_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q,   rsp_err_d;
    logic [31:0] rsp_data_q,  rsp_data_d;
    logic        hold_err_q,  hold_err_d;
    logic        direct_q,    direct_d;

    logic          accept;
    logic          req_ok;
    logic          ld_ok;
    logic [AW-1:0] req_idx;
    logic [AW-1:0] ld_idx;
    logic [31:0]   rd_data;

    assign req_ready = (state_q == IDLE);
    assign accept    = req_valid && req_ready;
    assign req_ok    = addr_in_range(req_addr, BASE_ADDR, DEPTH_WORDS);
    assign ld_ok     = addr_in_range(ld_addr, BASE_ADDR, DEPTH_WORDS);
    assign req_idx   = AW'((req_addr - BASE_ADDR) >> 2);
    assign ld_idx    = AW'((ld_addr - BASE_ADDR) >> 2);

    inst_mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk     (clk),
        .wr_en   (ld_en && ld_ok),
        .wr_idx  (ld_idx),
        .wr_mask (ld_wmask),
        .wr_data (ld_data),
        .rd_en   (accept),
        .rd_idx  (req_idx),
        .rd_data (rd_data)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_data_d  = rsp_data_q;
        hold_err_d  = hold_err_q;
        direct_d    = direct_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 0) begin
                        // array read register already holds the word the cycle after accept
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = !req_ok;
                        direct_d    = 1'b1;
                    end else begin
                        state_d    = WAIT;
                        hold_err_d = !req_ok;
                        cnt_d      = 4'(LATENCY);
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = hold_err_q;
                    rsp_data_d  = hold_err_q ? FAULT_DATA : rd_data;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= 32'h0;
            hold_err_q  <= 1'b0;
            direct_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
            hold_err_q  <= hold_err_d;
            direct_q    <= direct_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_data  = direct_q ? (rsp_err_q ? FAULT_DATA : rd_data) : rsp_data_q;

endmodule
`default_nettype wire
